audio_frame_scheduler: RTL
==========================

Name: audio_frame_scheduler

Overview:
- Consumer-side sequencer for the multichannel audio input FIFO.
- Waits until every channel holds a sample, then shares the current parallel frame among NUM_REQ DSP engines using round-robin grant/done handshakes.
- Once every enabled engine is served, or on timeout, it issues an advance request to the FIFO.
- Keeps overrun and timeout statistics for the debug wrapper.

Parameters:
NUM_REQ, 4, number of consumer engines sharing the frame
TIMEOUT_CYCLES, 1024, max sys_clk cycles in SERVE before a forced advance; must be >= 2
SEQ_W, 8, frame sequence counter width
CNT_W, 16, statistics counter width

Ports:
sys_clk  in  1  system clock
sys_rst_n  in  1  reset, asynchronous, active-low
buffer_ready  in  1  FIFO: all channels hold at least one sample
buffer_full  in  1  FIFO: any channel full (oldest sample being dropped)
adv_read_req  out  1  level request to FIFO; FIFO edge-detects, so each advance is high exactly 1 cycle then low
enable_mask  in  NUM_REQ  engines participating; latched at frame start
req  in  NUM_REQ  engine i wants the current frame
done  in  NUM_REQ  engine i finished with the frame; sampled only while grant[i]=1
grant  out  NUM_REQ  one-hot or zero; engine i may read FIFO outputs
frame_valid  out  1  FIFO outputs are stable and belong to frame frame_seq
frame_seq  out  SEQ_W  index of the current frame; wraps
timeout_flag  out  1  sticky; a frame was force-advanced
clr_flags  in  1  synchronous clear of timeout_flag and both counters
timeout_count  out  CNT_W  forced advances; saturating
overrun_count  out  CNT_W  rising edges of buffer_full; saturating

Behaviour:
- Reset values: all outputs 0; state WAIT_READY; round-robin pointer 0; served mask 0.
- Reset mid-operation drops grant and adv_read_req immediately (asynchronous).
- FSM states: WAIT_READY, SERVE, ADVANCE, SETTLE.
- WAIT_READY, on buffer_ready=1:
  - latch enable_mask into mask_l; clear served; reset timeout timer.
  - go to SERVE next cycle.
- SERVE:
  - frame_valid=1.
  - When grant==0, winner = first set bit of req & mask_l & ~served, searching from the pointer upward with wrap. grant is registered 1 cycle after the winner is computed.
  - grant[i] holds until done[i]=1. On that edge: grant→0, served[i]=1, pointer=(i+1) mod NUM_REQ.
  - done on a non-granted line is ignored. Minimum one idle cycle between consecutive grants.
  - Exit condition: served==mask_l.
  - mask_l==0 exits after one cycle in SERVE, with no grants (drain mode).
- Timeout:
  - The timer counts cycles in SERVE.
  - When it reaches TIMEOUT_CYCLES: grant→0, timeout_flag=1, timeout_count++, go to ADVANCE.
  - A done arriving in the same cycle is discarded.
- ADVANCE: adv_read_req=1 for exactly 1 cycle; frame_valid=0; frame_seq++ (wraps 2^SEQ_W-1→0).
- SETTLE:
  - Exactly 1 cycle with adv_read_req=0. This guarantees the FIFO sees a fresh rising edge and its read pointer or output has updated.
  - Then go to WAIT_READY.
  - Minimum frame period is therefore 4 cycles (drain mode).
- Statistics:
  - overrun_count counts a buffer_full rising edge, detected with a registered previous value in any state.
  - Both counters saturate at all-ones.
  - If clr_flags coincides with an increment event, clear wins.
- Changing enable_mask during SERVE has no effect until the next frame.
- Arithmetic: pointer width $clog2(NUM_REQ) (min 1); timer width $clog2(TIMEOUT_CYCLES+1).

Optional Feature:
- Macro: LLAC_SCHED_STATS_EN.
- Defined: timeout_count, overrun_count and the buffer_full edge register are implemented as above.
- Undefined:
  - Both count outputs tie to 0 and the counter logic is removed.
  - timeout_flag, the timeout advance and clr_flags (flag clear only) remain.

Decomposition:
- Package llac_sched_pkg: sched_state_e enum (WAIT_READY, SERVE, ADVANCE, SETTLE); width helper localparams; default TIMEOUT_CYCLES constant.
- Sub-module sched_rr_arbiter (combinational): inputs are the request vector and pointer; outputs are the one-hot winner and an any-valid flag. The module is parameterised on NUM_REQ.
- The buffer_full edge uses the existing Common pos_edge_det.

Test Plan:
- Reset mid-SERVE: with grant=0100, drop sys_rst_n → grant=0 and adv_read_req=0 immediately; after release, state WAIT_READY and frame_seq=0.
- Round-robin fairness: mask=1111, all req=1, each done 2 cycles after grant → grant order 0001,0010,0100,1000. Next frame also starts at 0001 because the pointer wraps. adv_read_req pulses 1 cycle and frame_seq increments by 1 per frame.
- Partial mask: mask=0101, req=1111 → only grants 0001 then 0100; done[1] pulses are ignored; advance after the second done.
- Timeout: TIMEOUT_CYCLES=16, mask=0011, engine 1 never asserts done → forced advance 16 cycles after SERVE entry. timeout_flag=1, timeout_count=1, grant cleared the same cycle.
- Drain and edge spacing: mask=0, buffer_ready held 1 → adv_read_req pattern 1,0,0,0 repeating (4-cycle period), never high on consecutive cycles.
- Overrun and saturation: toggle buffer_full 5 times → overrun_count=5. clr_flags coincident with the 6th edge → 0. With the macro undefined, the count stays 0.

Source files
------------

// File: rtl/llac_sched_pkg.sv
// Shared types and width helpers for the audio frame scheduler.
package llac_sched_pkg;

  typedef enum logic [1:0] {
    WAIT_READY = 2'd0,
    SERVE      = 2'd1,
    ADVANCE    = 2'd2,
    SETTLE     = 2'd3
  } sched_state_e;

  localparam int unsigned DEFAULT_TIMEOUT_CYCLES = 1024;
  localparam int unsigned DEFAULT_NUM_REQ        = 4;
  localparam int unsigned DEFAULT_SEQ_W          = 8;
  localparam int unsigned DEFAULT_CNT_W          = 16;

  // Round-robin pointer width; never narrower than one bit.
  function automatic int unsigned ptr_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Serve-timer width; must be able to hold the timeout value itself.
  function automatic int unsigned timer_width(input int unsigned t);
    return $clog2(t + 1);
  endfunction

endpackage

// File: rtl/pos_edge_det.sv
// Common rising-edge detector: registered previous value, combinational pulse.
// Only the statistics build (LLAC_SCHED_STATS_EN) instantiates it.
`ifdef LLAC_SCHED_STATS_EN
module pos_edge_det (
  input  logic clk,
  input  logic rst_n,
  input  logic sig_in,
  output logic rise_pulse
);

  logic sig_q;

  // Remember last cycle's level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sig_q <= 1'b0;
    else        sig_q <= sig_in;
  end

  assign rise_pulse = sig_in & ~sig_q;

endmodule
`endif

// File: rtl/sched_rr_arbiter.sv
// Combinational round-robin arbiter: first set request at or above the
// pointer, wrapping around; returns a one-hot winner and an any-valid flag.
module sched_rr_arbiter
  import llac_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ = DEFAULT_NUM_REQ,
  localparam int unsigned PTR_W  = ptr_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_vec,
  input  logic [PTR_W-1:0]   pointer,
  output logic [NUM_REQ-1:0] winner,
  output logic               any_valid
);

  logic [PTR_W-1:0] idx;

  // Scan from the pointer upward with wrap; the first hit wins.
  always_comb begin
    winner    = '0;
    any_valid = 1'b0;
    idx       = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      idx = PTR_W'((32'(pointer) + k) % NUM_REQ);
      if (!any_valid && req_vec[idx]) begin
        winner[idx] = 1'b1;
        any_valid   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/audio_frame_scheduler.sv
// Consumer-side sequencer for the multichannel audio input FIFO.
// Waits for a complete frame, hands it round-robin to the DSP engines, then
// pulses an advance request. Optional statistics counters are built only
// when LLAC_SCHED_STATS_EN is defined; otherwise the counts read as zero.
module audio_frame_scheduler
  import llac_sched_pkg::*;
#(
  parameter int unsigned NUM_REQ        = DEFAULT_NUM_REQ,
  parameter int unsigned TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int unsigned SEQ_W          = DEFAULT_SEQ_W,
  parameter int unsigned CNT_W          = DEFAULT_CNT_W
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic               buffer_ready,
  input  logic               buffer_full,
  output logic               adv_read_req,
  input  logic [NUM_REQ-1:0] enable_mask,
  input  logic [NUM_REQ-1:0] req,
  input  logic [NUM_REQ-1:0] done,
  output logic [NUM_REQ-1:0] grant,
  output logic               frame_valid,
  output logic [SEQ_W-1:0]   frame_seq,
  output logic               timeout_flag,
  input  logic               clr_flags,
  output logic [CNT_W-1:0]   timeout_count,
  output logic [CNT_W-1:0]   overrun_count
);

  localparam int unsigned      PTR_W     = ptr_width(NUM_REQ);
  localparam int unsigned      TMR_W     = timer_width(TIMEOUT_CYCLES);
  localparam logic [TMR_W-1:0] TMR_LIMIT = TMR_W'(TIMEOUT_CYCLES);
  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(NUM_REQ - 1);

  sched_state_e       state, state_nx;
  logic [NUM_REQ-1:0] mask_l;
  logic [NUM_REQ-1:0] served;
  logic [NUM_REQ-1:0] grant_r;
  logic [PTR_W-1:0]   ptr;
  logic [TMR_W-1:0]   timer;
  logic [SEQ_W-1:0]   seq;
  logic               tflag;

  logic [NUM_REQ-1:0] arb_req;
  logic [NUM_REQ-1:0] arb_win;
  logic               arb_any;
  logic               all_served;
  logic               timer_hit;
  logic               timeout_evt;
  logic               grant_done;
  logic [PTR_W-1:0]   done_idx;
  logic [PTR_W-1:0]   ptr_after;

  assign arb_req = req & mask_l & ~served;

  sched_rr_arbiter #(
    .NUM_REQ (NUM_REQ)
  ) u_arb (
    .req_vec   (arb_req),
    .pointer   (ptr),
    .winner    (arb_win),
    .any_valid (arb_any)
  );

  assign all_served  = (served == mask_l);
  assign timer_hit   = ((timer + 1'b1) == TMR_LIMIT);
  // Completing the frame on the last allowed cycle counts as a normal finish.
  assign timeout_evt = (state == SERVE) && !all_served && timer_hit;
  assign grant_done  = |(grant_r & done);

  // Index of the engine currently holding the grant.
  always_comb begin
    done_idx = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      if (grant_r[k]) done_idx = PTR_W'(k);
    end
  end

  assign ptr_after = (done_idx == PTR_LAST) ? '0 : done_idx + 1'b1;

  // State register.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) state <= WAIT_READY;
    else            state <= state_nx;
  end

  // Next-state decode.
  always_comb begin
    state_nx = state;
    case (state)
      WAIT_READY: if (buffer_ready) state_nx = SERVE;
      SERVE:      if (all_served || timer_hit) state_nx = ADVANCE;
      ADVANCE:    state_nx = SETTLE;
      SETTLE:     state_nx = WAIT_READY;
      default:    state_nx = WAIT_READY;
    endcase
  end

  // Frame bookkeeping: mask latch, grants, served set, pointer, timer, sequence.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      mask_l  <= '0;
      served  <= '0;
      grant_r <= '0;
      ptr     <= '0;
      timer   <= '0;
      seq     <= '0;
    end else begin
      case (state)
        WAIT_READY: begin
          if (buffer_ready) begin
            mask_l <= enable_mask;
            served <= '0;
            timer  <= '0;
          end
        end
        SERVE: begin
          timer <= timer + 1'b1;
          // Timeout outranks a coincident done: the grant drops and that
          // engine is not marked served, and the pointer stays put.
          if (timeout_evt) begin
            grant_r <= '0;
          end else if (grant_r != '0) begin
            if (grant_done) begin
              grant_r <= '0;
              served  <= served | grant_r;
              ptr     <= ptr_after;
            end
          end else if (!all_served && arb_any) begin
            grant_r <= arb_win;
          end
        end
        ADVANCE: seq <= seq + 1'b1;
        default: ;
      endcase
    end
  end

  // Sticky timeout flag; clear has priority over a new timeout.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)       tflag <= 1'b0;
    else if (clr_flags)   tflag <= 1'b0;
    else if (timeout_evt) tflag <= 1'b1;
  end

`ifdef LLAC_SCHED_STATS_EN
  logic             full_rise;
  logic [CNT_W-1:0] tcnt;
  logic [CNT_W-1:0] ocnt;

  pos_edge_det u_full_edge (
    .clk        (sys_clk),
    .rst_n      (sys_rst_n),
    .sig_in     (buffer_full),
    .rise_pulse (full_rise)
  );

  // Saturating statistics; clear wins over a coincident increment.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tcnt <= '0;
      ocnt <= '0;
    end else if (clr_flags) begin
      tcnt <= '0;
      ocnt <= '0;
    end else begin
      if (timeout_evt && (tcnt != '1)) tcnt <= tcnt + 1'b1;
      if (full_rise && (ocnt != '1))   ocnt <= ocnt + 1'b1;
    end
  end

  assign timeout_count = tcnt;
  assign overrun_count = ocnt;
`else
  logic unused_buffer_full;
  assign unused_buffer_full = buffer_full;
  assign timeout_count      = '0;
  assign overrun_count      = '0;
`endif

  assign grant        = grant_r;
  assign frame_valid  = (state == SERVE);
  assign adv_read_req = (state == ADVANCE);
  assign frame_seq    = seq;
  assign timeout_flag = tflag;

endmodule
